trap_ctrl: RTL and testbench
============================

Name: trap_ctrl

Overview:
- Machine-mode trap sequencer at the writeback boundary.
- Collects synchronous exception flags and MRET from the WB stage, plus a synchronised external interrupt. Prioritises them and drives the WB_TRAP record (trap_info_t) into the CSR file.
- Flushes the pipeline, waits for the CSR file's registered handler address to settle, then issues a one-cycle fetch redirect to the handler or to MEPC.

Parameters:
- HANDLER_LATENCY, 2, cycles between trap acceptance and handler redirect; covers the mtvec→TRAP_HANDLER_ADDR register path in the CSR file; legal range 1..7.
- IRQ_SYNC_STAGES, 2, flops in the IRQ synchroniser; legal range 2..3.

Ports:
- CLK in 1 clock
- RST_N in 1 asynchronous active-low reset
- WB_VALID_INSN in 1 WB holds a valid, un-squashed instruction
- WB_PC in 32 PC of the WB instruction
- WB_EXC_FETCH_MISALIGN in 1 instruction address misaligned
- WB_EXC_ILLEGAL in 1 illegal instruction
- WB_EXC_ECALL in 1 ECALL
- WB_EXC_EBREAK in 1 EBREAK
- WB_EXC_LOAD_MISALIGN in 1 load address misaligned
- WB_EXC_STORE_MISALIGN in 1 store address misaligned
- WB_MRET in 1 WB instruction is MRET
- IRQ in 1 asynchronous level-sensitive external interrupt
- TRAP_HANDLER_ADDR in 32 registered handler base from the CSR file
- CSR_MEPC in 32 current mepc from the CSR file
- WB_TRAP out trap_info_t trap record consumed by the CSR file
- FLUSH out 1 squash IF..WB
- REDIRECT_VALID out 1 one-cycle fetch redirect strobe
- REDIRECT_PC out 32 redirect target
- IN_HANDLER out 1 trap taken, MRET not yet executed

Behaviour:
- Reset (async, RST_N=0):
  - state=IDLE; FLUSH, REDIRECT_VALID, IN_HANDLER = 0; REDIRECT_PC = 0.
  - WB_TRAP all fields 0; synchroniser flops 0; wait counter 0.
  - Reset mid-sequence aborts it; no redirect is emitted after release.
- IRQ path: IRQ_SYNC_STAGES-flop synchroniser produces irq_s. IRQ is level-sensitive, not latched; deassertion before acceptance drops the request.
- Acceptance in IDLE, only while WB_VALID_INSN=1. Priority, highest first:
  1. fetch misaligned, cause 0
  2. illegal, cause 2
  3. ebreak, cause 3
  4. ecall, cause 11
  5. load misaligned, cause 4
  6. store misaligned, cause 6
  7. interrupt: irq_s & !IN_HANDLER & no exception; cause 11, is_interrupt=1
  8. MRET
- WB_TRAP is combinational in IDLE:
  - valid=1 on an accepted exception or interrupt.
  - pc=WB_PC.
  - mcause is 31 bits, zero-extended.
  - In all other states WB_TRAP.valid=0.
- Accept cycle t (trap): FLUSH=1 combinationally in cycle t; IN_HANDLER←1; counter←HANDLER_LATENCY-1; state←WAIT_TRAP.
- WAIT_TRAP: FLUSH=1; counter decrements; at 0 → REDIRECT.
- REDIRECT (1 cycle):
  - REDIRECT_VALID=1, REDIRECT_PC={TRAP_HANDLER_ADDR[31:2],2'b00}, FLUSH=1.
  - Next state is IDLE.
  - For a trap, REDIRECT_VALID is seen at cycle t+HANDLER_LATENCY+1.
- MRET accepted in cycle t:
  - FLUSH=1; IN_HANDLER←0; state←WAIT_MRET (1 cycle).
  - Then REDIRECT with REDIRECT_PC=CSR_MEPC sampled in the REDIRECT cycle.
  - The redirect is seen at t+2.
- REDIRECT_PC holds its last value outside REDIRECT.
- Non-IDLE states ignore all WB inputs; the pipeline is flushed so none are valid.
- Exception while IN_HANDLER=1 is still taken: mepc/mcause overwritten and IN_HANDLER stays 1. Interrupts stay masked.
- Simultaneous MRET and exception: the exception wins; IN_HANDLER stays 1.
- WB_VALID_INSN=0: nothing accepted, including a pending interrupt.

Decomposition:
- Add to params_pkg:
  - MCAUSE_* constants (0,2,3,4,6,11, interrupt 11).
  - trap_state_e {IDLE, WAIT_TRAP, WAIT_MRET, REDIRECT}.
- Reuse the existing trap_info_t.
- One sub-module: sync_ff (parameterised N-stage synchroniser, async active-low reset).

Test Plan:
1. Illegal trap: WB_VALID_INSN=1, WB_EXC_ILLEGAL=1, WB_PC=0x100, TRAP_HANDLER_ADDR=0x8000_0040.
   - Same cycle: WB_TRAP={valid=1, pc=0x100, int=0, mcause=2}, FLUSH=1.
   - 3 cycles later: REDIRECT_VALID=1 for 1 cycle with REDIRECT_PC=0x8000_0040; IN_HANDLER=1.
2. Priority: illegal+ecall+load_misalign together → mcause=2. Fetch_misalign+ebreak → mcause=0.
3. IRQ: raise IRQ with a valid WB at PC 0x200.
   - After 2 sync cycles: WB_TRAP={1, 0x200, int=1, mcause=11}.
   - A second IRQ while IN_HANDLER=1 → no trap.
4. MRET with CSR_MEPC=0x204: FLUSH=1, IN_HANDLER→0, REDIRECT_PC=0x204 two cycles later. A pending IRQ is then accepted on the next valid WB.
5. Drive RST_N=0 in WAIT_TRAP, release → no REDIRECT_VALID, all outputs 0, state IDLE.
6. Exception plus MRET same cycle → trap taken, IN_HANDLER remains 1. WB_VALID_INSN=0 with exception flags set → nothing accepted.

Source files
------------

// File: rtl/trap_ctrl_pkg.sv
// Shared types and constants for the machine-mode trap sequencer.
package trap_ctrl_pkg;

    localparam logic [30:0] MCAUSE_FETCH_MISALIGN = 31'd0;
    localparam logic [30:0] MCAUSE_ILLEGAL        = 31'd2;
    localparam logic [30:0] MCAUSE_EBREAK         = 31'd3;
    localparam logic [30:0] MCAUSE_LOAD_MISALIGN  = 31'd4;
    localparam logic [30:0] MCAUSE_STORE_MISALIGN = 31'd6;
    localparam logic [30:0] MCAUSE_ECALL          = 31'd11;
    localparam logic [30:0] MCAUSE_EXT_IRQ        = 31'd11;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_TRAP,
        WAIT_MRET,
        REDIRECT
    } trap_state_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        is_interrupt;
        logic [30:0] mcause;
    } trap_info_t;

    function automatic logic [31:0] align4(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/trap_ctrl_if.sv
// WB-stage trap inputs, CSR handshake and fetch-redirect outputs of the trap sequencer.
interface trap_ctrl_if;
    import trap_ctrl_pkg::*;

    logic        WB_VALID_INSN;
    logic [31:0] WB_PC;
    logic        WB_EXC_FETCH_MISALIGN;
    logic        WB_EXC_ILLEGAL;
    logic        WB_EXC_ECALL;
    logic        WB_EXC_EBREAK;
    logic        WB_EXC_LOAD_MISALIGN;
    logic        WB_EXC_STORE_MISALIGN;
    logic        WB_MRET;
    logic        IRQ;
    logic [31:0] TRAP_HANDLER_ADDR;
    logic [31:0] CSR_MEPC;
    trap_info_t  WB_TRAP;
    logic        FLUSH;
    logic        REDIRECT_VALID;
    logic [31:0] REDIRECT_PC;
    logic        IN_HANDLER;

    modport master (
        output WB_VALID_INSN, WB_PC, WB_EXC_FETCH_MISALIGN, WB_EXC_ILLEGAL,
               WB_EXC_ECALL, WB_EXC_EBREAK, WB_EXC_LOAD_MISALIGN,
               WB_EXC_STORE_MISALIGN, WB_MRET, IRQ, TRAP_HANDLER_ADDR, CSR_MEPC,
        input  WB_TRAP, FLUSH, REDIRECT_VALID, REDIRECT_PC, IN_HANDLER
    );

    modport slave (
        input  WB_VALID_INSN, WB_PC, WB_EXC_FETCH_MISALIGN, WB_EXC_ILLEGAL,
               WB_EXC_ECALL, WB_EXC_EBREAK, WB_EXC_LOAD_MISALIGN,
               WB_EXC_STORE_MISALIGN, WB_MRET, IRQ, TRAP_HANDLER_ADDR, CSR_MEPC,
        output WB_TRAP, FLUSH, REDIRECT_VALID, REDIRECT_PC, IN_HANDLER
    );

endinterface

// File: rtl/trap_ctrl_sync_ff.sv
// N-stage flop synchroniser for an asynchronous level; latency N cycles.
// No backpressure: samples every cycle, cleared by async reset.
module sync_ff #(
    parameter int N = 2
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic D,
    output logic Q
);

    logic [N-1:0] stg;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) stg <= '0;
        else        stg <= {stg[N-2:0], D};
    end

    assign Q = stg[N-1];

endmodule

// File: rtl/trap_ctrl.sv
// Machine-mode trap sequencer: prioritises WB exceptions, IRQ and MRET, flushes, then redirects fetch.
// Latency: trap redirect at accept+HANDLER_LATENCY+1, MRET redirect at accept+2.
// Backpressure: none; while a sequence is in flight FLUSH holds the pipeline empty and WB inputs are ignored.
module trap_ctrl
    import trap_ctrl_pkg::*;
#(
    parameter int HANDLER_LATENCY = 2,
    parameter int IRQ_SYNC_STAGES = 2
) (
    input  logic         CLK,
    input  logic         RST_N,
    trap_ctrl_if.slave   tif
);

    trap_state_e state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        in_handler_q, in_handler_d;
    logic        redir_mret_q, redir_mret_d;
    logic [31:0] rpc_q;
    logic [31:0] rtarget;
    logic        irq_s;
    logic        exc_any;
    logic [30:0] exc_cause;
    logic        flush;
    logic        rvalid;
    trap_info_t  trap;

    sync_ff #(.N(IRQ_SYNC_STAGES)) u_irq_sync (
        .CLK   (CLK),
        .RST_N (RST_N),
        .D     (tif.IRQ),
        .Q     (irq_s)
    );

    // Exception priority: earlier arms win.
    always_comb begin
        exc_any   = 1'b1;
        exc_cause = MCAUSE_FETCH_MISALIGN;
        if      (tif.WB_EXC_FETCH_MISALIGN) exc_cause = MCAUSE_FETCH_MISALIGN;
        else if (tif.WB_EXC_ILLEGAL)        exc_cause = MCAUSE_ILLEGAL;
        else if (tif.WB_EXC_EBREAK)         exc_cause = MCAUSE_EBREAK;
        else if (tif.WB_EXC_ECALL)          exc_cause = MCAUSE_ECALL;
        else if (tif.WB_EXC_LOAD_MISALIGN)  exc_cause = MCAUSE_LOAD_MISALIGN;
        else if (tif.WB_EXC_STORE_MISALIGN) exc_cause = MCAUSE_STORE_MISALIGN;
        else                                exc_any   = 1'b0;
    end

    assign rtarget = redir_mret_q ? tif.CSR_MEPC : align4(tif.TRAP_HANDLER_ADDR);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        in_handler_d = in_handler_q;
        redir_mret_d = redir_mret_q;
        trap         = '0;
        flush        = 1'b0;
        rvalid       = 1'b0;
        unique case (state_q)
            IDLE: begin
                trap.pc = tif.WB_PC;
                if (tif.WB_VALID_INSN) begin
                    if (exc_any) begin
                        trap.valid  = 1'b1;
                        trap.mcause = exc_cause;
                    end else if (irq_s && !in_handler_q) begin
                        trap.valid        = 1'b1;
                        trap.is_interrupt = 1'b1;
                        trap.mcause       = MCAUSE_EXT_IRQ;
                    end
                    if (trap.valid) begin
                        flush        = 1'b1;
                        in_handler_d = 1'b1;
                        redir_mret_d = 1'b0;
                        cnt_d        = 3'(HANDLER_LATENCY - 1);
                        state_d      = WAIT_TRAP;
                    end else if (tif.WB_MRET) begin
                        flush        = 1'b1;
                        in_handler_d = 1'b0;
                        redir_mret_d = 1'b1;
                        state_d      = WAIT_MRET;
                    end
                end
            end
            WAIT_TRAP: begin
                flush = 1'b1;
                if (cnt_q == 3'd0) state_d = REDIRECT;
                else               cnt_d   = cnt_q - 3'd1;
            end
            WAIT_MRET: begin
                flush   = 1'b1;
                state_d = REDIRECT;
            end
            REDIRECT: begin
                flush   = 1'b1;
                rvalid  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            in_handler_q <= 1'b0;
            redir_mret_q <= 1'b0;
            rpc_q        <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            in_handler_q <= in_handler_d;
            redir_mret_q <= redir_mret_d;
            if (rvalid) rpc_q <= rtarget;
        end
    end

    assign tif.WB_TRAP        = trap;
    assign tif.FLUSH          = flush;
    assign tif.REDIRECT_VALID = rvalid;
    assign tif.REDIRECT_PC    = rvalid ? rtarget : rpc_q;
    assign tif.IN_HANDLER     = in_handler_q;

endmodule

// File: tb/tb_trap_ctrl.sv
// Bench for trap_ctrl: directed scenarios plus random traffic against an event-time reference model.
module tb_trap_ctrl;
    import trap_ctrl_pkg::*;

    localparam int HL = 2;
    localparam int NS = 2;

    logic CLK = 1'b0;
    logic RST_N;
    always #5 CLK = ~CLK;

    trap_ctrl_if tif ();

    trap_ctrl #(.HANDLER_LATENCY(HL), .IRQ_SYNC_STAGES(NS)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .tif   (tif)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    // Reference model: IRQ history per clock edge, in-handler flag, and the
    // absolute cycle at which the pending redirect must appear.
    bit          hist[$];
    bit          m_inh;
    int          m_redir_at;
    bit          m_redir_mret;
    logic [31:0] m_last_rpc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_inh        = 1'b0;
        m_redir_at   = -1;
        m_redir_mret = 1'b0;
        m_last_rpc   = '0;
    endtask

    task automatic drive_idle();
        tif.WB_VALID_INSN         = 1'b0;
        tif.WB_PC                 = '0;
        tif.WB_EXC_FETCH_MISALIGN = 1'b0;
        tif.WB_EXC_ILLEGAL        = 1'b0;
        tif.WB_EXC_ECALL          = 1'b0;
        tif.WB_EXC_EBREAK         = 1'b0;
        tif.WB_EXC_LOAD_MISALIGN  = 1'b0;
        tif.WB_EXC_STORE_MISALIGN = 1'b0;
        tif.WB_MRET               = 1'b0;
    endtask

    task automatic tick();
        @(posedge CLK);
        hist.push_back(RST_N ? tif.IRQ : 1'b0);
        if (hist.size() > 8) void'(hist.pop_front());
        cyc++;
        #1;
    endtask

    function automatic bit model_irq_s();
        if (hist.size() < NS) return 1'b0;
        return hist[hist.size() - NS];
    endfunction

    // The single compare point: run once per cycle at the falling edge.
    task automatic check();
        bit          pending, rv, take_trap, take_mret, is_int;
        logic [30:0] cause;
        logic [31:0] tgt;
        bit          fl[6];
        int          cs[6];
        @(negedge CLK);
        if (!RST_N) begin
            chk("rst_trap", 64'(tif.WB_TRAP), 64'd0);
            chk("rst_flush", 64'(tif.FLUSH), 64'd0);
            chk("rst_rvalid", 64'(tif.REDIRECT_VALID), 64'd0);
            chk("rst_rpc", 64'(tif.REDIRECT_PC), 64'd0);
            chk("rst_inh", 64'(tif.IN_HANDLER), 64'd0);
            return;
        end
        chk("in_handler", 64'(tif.IN_HANDLER), 64'(m_inh));
        pending = (m_redir_at >= cyc);
        if (pending) begin
            chk("busy_trap_valid", 64'(tif.WB_TRAP.valid), 64'd0);
            chk("busy_flush", 64'(tif.FLUSH), 64'd1);
            rv = (cyc == m_redir_at);
            chk("busy_rvalid", 64'(tif.REDIRECT_VALID), 64'(rv));
            if (rv) begin
                tgt = m_redir_mret ? tif.CSR_MEPC : (tif.TRAP_HANDLER_ADDR & 32'hFFFF_FFFC);
                m_last_rpc = tgt;
            end
            chk("rpc", 64'(tif.REDIRECT_PC), 64'(m_last_rpc));
            return;
        end
        fl = '{tif.WB_EXC_FETCH_MISALIGN, tif.WB_EXC_ILLEGAL, tif.WB_EXC_EBREAK,
               tif.WB_EXC_ECALL, tif.WB_EXC_LOAD_MISALIGN, tif.WB_EXC_STORE_MISALIGN};
        cs = '{0, 2, 3, 11, 4, 6};
        take_trap = 1'b0;
        is_int    = 1'b0;
        cause     = '0;
        for (int i = 5; i >= 0; i--) begin
            if (fl[i]) begin
                take_trap = 1'b1;
                cause     = 31'(cs[i]);
            end
        end
        if (!take_trap && model_irq_s() && !m_inh) begin
            take_trap = 1'b1;
            is_int    = 1'b1;
            cause     = 31'd11;
        end
        take_trap = take_trap && tif.WB_VALID_INSN;
        take_mret = tif.WB_VALID_INSN && tif.WB_MRET && !take_trap;
        chk("trap_valid", 64'(tif.WB_TRAP.valid), 64'(take_trap));
        if (take_trap) begin
            chk("trap_pc", 64'(tif.WB_TRAP.pc), 64'(tif.WB_PC));
            chk("trap_int", 64'(tif.WB_TRAP.is_interrupt), 64'(is_int));
            chk("trap_mcause", 64'(tif.WB_TRAP.mcause), 64'(cause));
        end
        chk("idle_flush", 64'(tif.FLUSH), 64'(take_trap || take_mret));
        chk("idle_rvalid", 64'(tif.REDIRECT_VALID), 64'd0);
        chk("idle_rpc", 64'(tif.REDIRECT_PC), 64'(m_last_rpc));
        if (take_trap) begin
            m_inh        = 1'b1;
            m_redir_at   = cyc + HL + 1;
            m_redir_mret = 1'b0;
        end else if (take_mret) begin
            m_inh        = 1'b0;
            m_redir_at   = cyc + 2;
            m_redir_mret = 1'b1;
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            drive_idle();
            check();
        end
    endtask

    initial begin
        RST_N = 1'b0;
        drive_idle();
        tif.IRQ               = 1'b0;
        tif.TRAP_HANDLER_ADDR = '0;
        tif.CSR_MEPC          = '0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            tick();
            check();
        end
        tick();
        RST_N = 1'b1;
        check();

        // Illegal trap and its redirect timing
        tick();
        tif.WB_VALID_INSN = 1'b1; tif.WB_EXC_ILLEGAL = 1'b1; tif.WB_PC = 32'h100;
        tif.TRAP_HANDLER_ADDR = 32'h8000_0040;
        check();
        chk("t1_valid", 64'(tif.WB_TRAP.valid), 64'd1);
        chk("t1_pc", 64'(tif.WB_TRAP.pc), 64'h100);
        chk("t1_mcause", 64'(tif.WB_TRAP.mcause), 64'd2);
        chk("t1_flush", 64'(tif.FLUSH), 64'd1);
        idle_cycles(2);
        chk("t1_no_early_redirect", 64'(tif.REDIRECT_VALID), 64'd0);
        idle_cycles(1);
        chk("t1_rvalid", 64'(tif.REDIRECT_VALID), 64'd1);
        chk("t1_rpc", 64'(tif.REDIRECT_PC), 64'h8000_0040);
        chk("t1_inh", 64'(tif.IN_HANDLER), 64'd1);
        idle_cycles(1);
        chk("t1_rvalid_drop", 64'(tif.REDIRECT_VALID), 64'd0);

        // Priority
        tick();
        tif.WB_VALID_INSN = 1'b1; tif.WB_EXC_ILLEGAL = 1'b1; tif.WB_EXC_ECALL = 1'b1;
        tif.WB_EXC_LOAD_MISALIGN = 1'b1; tif.WB_PC = 32'h110;
        check();
        chk("t2_mcause_a", 64'(tif.WB_TRAP.mcause), 64'd2);
        idle_cycles(3);
        tick();
        tif.WB_VALID_INSN = 1'b1; tif.WB_EXC_FETCH_MISALIGN = 1'b1; tif.WB_EXC_EBREAK = 1'b1;
        tif.WB_PC = 32'h120;
        check();
        chk("t2_mcause_b", 64'(tif.WB_TRAP.mcause), 64'd0);
        idle_cycles(3);

        // Leave the handler before the IRQ scenario
        tick();
        tif.WB_VALID_INSN = 1'b1; tif.WB_MRET = 1'b1; tif.CSR_MEPC = 32'h40;
        check();
        idle_cycles(2);

        // IRQ through the synchroniser
        tick();
        tif.IRQ = 1'b1; tif.WB_VALID_INSN = 1'b1; tif.WB_PC = 32'h200;
        check();
        chk("t3_not_yet", 64'(tif.WB_TRAP.valid), 64'd0);
        tick();
        check();
        tick();
        check();
        chk("t3_valid", 64'(tif.WB_TRAP.valid), 64'd1);
        chk("t3_pc", 64'(tif.WB_TRAP.pc), 64'h200);
        chk("t3_int", 64'(tif.WB_TRAP.is_interrupt), 64'd1);
        chk("t3_mcause", 64'(tif.WB_TRAP.mcause), 64'd11);
        idle_cycles(3);
        tick();
        tif.WB_VALID_INSN = 1'b1; tif.WB_PC = 32'h300;
        check();
        chk("t3_masked", 64'(tif.WB_TRAP.valid), 64'd0);

        // MRET then pending IRQ
        tick();
        tif.WB_VALID_INSN = 1'b1; tif.WB_MRET = 1'b1; tif.WB_PC = 32'h300; tif.CSR_MEPC = 32'h204;
        check();
        chk("t4_flush", 64'(tif.FLUSH), 64'd1);
        idle_cycles(1);
        chk("t4_inh", 64'(tif.IN_HANDLER), 64'd0);
        idle_cycles(1);
        chk("t4_rvalid", 64'(tif.REDIRECT_VALID), 64'd1);
        chk("t4_rpc", 64'(tif.REDIRECT_PC), 64'h204);
        tick();
        tif.WB_VALID_INSN = 1'b1; tif.WB_PC = 32'h208;
        check();
        chk("t4_irq_taken", 64'(tif.WB_TRAP.is_interrupt), 64'd1);
        tif.IRQ = 1'b0;
        idle_cycles(4);

        // Reset in WAIT_TRAP
        tick();
        tif.WB_VALID_INSN = 1'b1; tif.WB_EXC_ILLEGAL = 1'b1; tif.WB_PC = 32'h10;
        check();
        idle_cycles(1);
        tick();
        drive_idle();
        RST_N = 1'b0;
        model_reset();
        check();
        tick();
        check();
        tick();
        RST_N = 1'b1;
        check();
        for (int i = 0; i < 5; i++) begin
            idle_cycles(1);
            chk("t5_no_redirect", 64'(tif.REDIRECT_VALID), 64'd0);
        end
        chk("t5_inh", 64'(tif.IN_HANDLER), 64'd0);

        // Exception with MRET, then flags without a valid instruction
        tick();
        tif.WB_VALID_INSN = 1'b1; tif.WB_EXC_ECALL = 1'b1; tif.WB_MRET = 1'b1; tif.WB_PC = 32'h400;
        check();
        chk("t6_mcause", 64'(tif.WB_TRAP.mcause), 64'd11);
        idle_cycles(3);
        chk("t6_inh", 64'(tif.IN_HANDLER), 64'd1);
        tick();
        tif.WB_EXC_FETCH_MISALIGN = 1'b1; tif.WB_EXC_ILLEGAL = 1'b1; tif.WB_EXC_ECALL = 1'b1;
        tif.WB_EXC_EBREAK = 1'b1; tif.WB_EXC_LOAD_MISALIGN = 1'b1; tif.WB_EXC_STORE_MISALIGN = 1'b1;
        tif.WB_MRET = 1'b1;
        check();
        chk("t6_novalid", 64'(tif.WB_TRAP.valid), 64'd0);
        chk("t6_noflush", 64'(tif.FLUSH), 64'd0);

        // Random traffic
        for (int n = 0; n < 2000; n++) begin
            tick();
            if ($urandom_range(19) == 0) tif.IRQ = ~tif.IRQ;
            tif.WB_VALID_INSN         = ($urandom_range(3) != 0);
            tif.WB_PC                 = $urandom & 32'hFFFF_FFFC;
            tif.WB_EXC_FETCH_MISALIGN = ($urandom_range(29) == 0);
            tif.WB_EXC_ILLEGAL        = ($urandom_range(19) == 0);
            tif.WB_EXC_ECALL          = ($urandom_range(19) == 0);
            tif.WB_EXC_EBREAK         = ($urandom_range(19) == 0);
            tif.WB_EXC_LOAD_MISALIGN  = ($urandom_range(19) == 0);
            tif.WB_EXC_STORE_MISALIGN = ($urandom_range(19) == 0);
            tif.WB_MRET               = ($urandom_range(5) == 0);
            tif.TRAP_HANDLER_ADDR     = $urandom;
            tif.CSR_MEPC              = $urandom;
            check();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
